// File: rtl/dyna_cell_nary.sv
// One node of a dynamic tree: holds one token and drives up to N_CHILD child links.
// Loads a subtree in prefix order, reads it back serially and clears it on BOMB.
module dyna_cell_nary #(
  parameter int MSG_W   = 4,
  parameter int N_CHILD = 3,
  parameter int CH_W    = 2,
  parameter int IDX     = 0,
  parameter int TGT_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 glob_com,
  input  logic [MSG_W-1:0]           p_msg,
  input  logic [TGT_W-1:0]           p_tgt,
  input  logic [N_CHILD*MSG_W-1:0]   ch_msg,
  input  logic [N_CHILD*TGT_W-1:0]   ch_tgt,
  output logic [MSG_W-1:0]           o_msg,
  output logic [TGT_W-1:0]           o_tgt,
  output logic                       o_err
);

  localparam int IW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
  localparam int AW = $clog2(N_CHILD + 1);

  localparam logic [MSG_W-1:0] M_ZERO  = MSG_W'(0);
  localparam logic [MSG_W-1:0] M_READY = MSG_W'(1);
  localparam logic [MSG_W-1:0] M_BOMB  = MSG_W'(3);
  localparam logic [MSG_W-1:0] M_READ  = MSG_W'(4);
  localparam logic [MSG_W-1:0] M_STOP  = MSG_W'(6);
  localparam logic [MSG_W-1:0] M_EOF   = MSG_W'(7);

  localparam logic [TGT_W-1:0] T_PARENT = TGT_W'(0);
  localparam logic [TGT_W-1:0] T_ALL    = TGT_W'(1);
  localparam logic [TGT_W-1:0] T_SELF   = TGT_W'(IDX + 2);

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [AW-1:0] arity_of(input logic [CH_W-1:0] a);
    if (int'(a) > N_CHILD) return AW'(N_CHILD);
    else                   return AW'(a);
  endfunction

  function automatic logic arity_over(input logic [CH_W-1:0] a);
    return (int'(a) > N_CHILD);
  endfunction

  function automatic logic [TGT_W-1:0] child_tgt(input logic [IW-1:0] k);
    return TGT_W'(int'(k) + 32'sd2);
  endfunction

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   value_q, value_d;
  logic [IW-1:0]      wr_idx_q, wr_idx_d;
  logic [IW-1:0]      rd_idx_q, rd_idx_d;
  logic               cmd_sent_q, cmd_sent_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic               err_q, err_d;

  logic [MSG_W-1:0]   p_in;
  logic [MSG_W-1:0]   ch_view [N_CHILD];
  logic [MSG_W-1:0]   wr_ch, rd_ch;
  logic [AW-1:0]      arity, new_arity;
  logic               wr_last, rd_last;

  assign p_in      = (p_tgt == T_ALL || p_tgt == T_SELF) ? p_msg : M_ZERO;
  assign arity     = arity_of(value_q[CH_W-1:0]);
  assign new_arity = arity_of(p_in[CH_W-1:0]);
  assign wr_last   = (int'(wr_idx_q) == int'(arity) - 32'sd1);
  assign rd_last   = (int'(rd_idx_q) == int'(arity) - 32'sd1);

  // Child messages addressed to us, and the ones selected by the load/read cursors.
  always_comb begin
    wr_ch = M_ZERO;
    rd_ch = M_ZERO;
    for (int k = 0; k < N_CHILD; k++) begin
      ch_view[k] = (ch_tgt[k*TGT_W +: TGT_W] == T_PARENT) ? ch_msg[k*MSG_W +: MSG_W] : M_ZERO;
      wr_ch      = (wr_idx_q == IW'(k)) ? ch_view[k] : wr_ch;
      rd_ch      = (rd_idx_q == IW'(k)) ? ch_view[k] : rd_ch;
    end
  end

  // Next-state and next-output logic; BOMB overrides every state.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    cmd_sent_d = cmd_sent_q;
    msg_d      = M_ZERO;
    tgt_d      = T_PARENT;
    err_d      = err_q;

    if (p_in == M_BOMB) begin
      msg_d      = M_BOMB;
      tgt_d      = T_ALL;
      value_d    = M_ZERO;
      wr_idx_d   = IW'(0);
      rd_idx_d   = IW'(0);
      cmd_sent_d = 1'b0;
      state_d    = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (p_in != M_ZERO) begin
            value_d = p_in;
            err_d   = err_q | arity_over(p_in[CH_W-1:0]);
            if (new_arity == AW'(0)) begin
              msg_d   = M_READY;
              state_d = S_READY;
            end else begin
              wr_idx_d = IW'(0);
              state_d  = S_LOAD;
            end
          end else begin
            value_d = value_q;
          end
        end
        S_LOAD: begin
          msg_d = p_in;
          tgt_d = child_tgt(wr_idx_q);
          // A STOP link means the tree is deeper than the hardware: finish, but flag it.
          if (wr_ch == M_READY || wr_ch == M_STOP) begin
            err_d = err_q | (wr_ch == M_STOP);
            if (wr_last) begin
              msg_d   = M_READY;
              tgt_d   = T_PARENT;
              state_d = S_READY;
            end else begin
              wr_idx_d = wr_idx_q + IW'(1);
              tgt_d    = child_tgt(wr_idx_q + IW'(1));
            end
          end else begin
            wr_idx_d = wr_idx_q;
          end
        end
        S_READY: begin
          if (p_in == M_READ) begin
            msg_d      = value_q;
            rd_idx_d   = IW'(0);
            cmd_sent_d = 1'b0;
            state_d    = S_READ;
          end else if (p_in != M_ZERO) begin
            msg_d = M_READY;
            err_d = 1'b1;
          end else begin
            msg_d = M_READY;
          end
        end
        S_READ: begin
          if (arity == AW'(0)) begin
            msg_d   = M_EOF;
            state_d = S_DONE;
          end else if (!cmd_sent_q && rd_ch == M_READY) begin
            msg_d      = M_READ;
            tgt_d      = child_tgt(rd_idx_q);
            cmd_sent_d = 1'b1;
          end else if (rd_ch == M_EOF) begin
            if (rd_last) begin
              msg_d   = M_EOF;
              state_d = S_DONE;
            end else begin
              rd_idx_d   = rd_idx_q + IW'(1);
              cmd_sent_d = 1'b0;
              msg_d      = M_ZERO;
            end
          end else if (rd_ch == M_ZERO || rd_ch == M_READY) begin
            msg_d = M_ZERO;
          end else begin
            msg_d = rd_ch;
          end
        end
        S_DONE: begin
          msg_d   = M_READY;
          state_d = S_READY;
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // State and output registers with async reset, soft clear and global hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      value_q    <= M_ZERO;
      wr_idx_q   <= IW'(0);
      rd_idx_q   <= IW'(0);
      cmd_sent_q <= 1'b0;
      msg_q      <= M_ZERO;
      tgt_q      <= T_PARENT;
      err_q      <= 1'b0;
    end else if (glob_com[1]) begin
      state_q    <= S_EMPTY;
      value_q    <= M_ZERO;
      wr_idx_q   <= IW'(0);
      rd_idx_q   <= IW'(0);
      cmd_sent_q <= 1'b0;
      msg_q      <= M_ZERO;
      tgt_q      <= T_PARENT;
      err_q      <= 1'b0;
    end else if (glob_com == 2'd1) begin
      state_q    <= state_q;
      value_q    <= value_q;
      wr_idx_q   <= wr_idx_q;
      rd_idx_q   <= rd_idx_q;
      cmd_sent_q <= cmd_sent_q;
      msg_q      <= msg_q;
      tgt_q      <= tgt_q;
      err_q      <= err_q;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      cmd_sent_q <= cmd_sent_d;
      msg_q      <= msg_d;
      tgt_q      <= tgt_d;
      err_q      <= err_d;
    end
  end

  assign o_msg = msg_q;
  assign o_tgt = tgt_q;
  assign o_err = err_q;

endmodule
